// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the sequenced scan arbiter.
// It holds the FSM state enum, the default pattern and the saturating match-count helper.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT,
    DONE
  } scan_state_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h60;
  localparam int         MATCH_CNT_W     = 8;

  function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_window.sv
// Bit-serial 8-bit window with a fill count and a registered, non-overlapping match flag.
// A match consumes the window: the fill count restarts from zero.
module pattern_window (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       bit_in,
  input  logic [7:0] pattern,
  output logic       match
);

  logic [7:0] win_q, win_d;
  logic [3:0] fill_q, fill_d;
  logic       match_q, match_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    win_d   = win_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clr) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_en) begin
      win_d  = {win_q[6:0], bit_in};
      fill_d = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
      if (fill_d == 4'd8 && win_d == pattern) begin
        match_d = 1'b1;
        fill_d  = '0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter that lends one serial pattern detector to N_REQ byte streams,
// one whole frame at a time, and reports matches and per-frame match counts.
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] PATTERN = DEFAULT_PATTERN,
  parameter int         IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][7:0]  req_data,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   match_pulse,
  output logic [IDW-1:0]         match_id,
  output logic                   frame_done,
  output logic [IDW-1:0]         frame_id,
  output logic [MATCH_CNT_W-1:0] frame_matches
);

  scan_state_t            state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [7:0]             sr_q, sr_d;
  logic                   last_q, last_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [MATCH_CNT_W-1:0] cnt_q, cnt_d;

  logic           win_clr, shift_en, win_match, any_valid;
  logic [IDW-1:0] winner;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return IDW'(sum);
  endfunction

  // Scan downward so the requester closest above rr_ptr is the last one written.
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_q;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_add(rr_ptr_q, i)]) begin
        winner    = wrap_add(rr_ptr_q, i);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    sr_d      = sr_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = win_match ? sat_inc(cnt_q) : cnt_q;
    req_ready = '0;
    win_clr   = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          grant_d   = winner;
          sr_d      = req_data[winner];
          last_d    = req_last[winner];
          win_clr   = 1'b1;
          cnt_d     = '0;
          bit_cnt_d = 3'd7;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_en  = 1'b1;
        sr_d      = {sr_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) state_d = last_q ? DONE : WAIT;
      end
      WAIT: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          sr_d      = req_data[grant_q];
          last_d    = req_last[grant_q];
          bit_cnt_d = 3'd7;
          state_d   = SHIFT;
        end
      end
      DONE: begin
        rr_ptr_d = wrap_add(grant_q, 1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      sr_q      <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      sr_q      <= sr_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  pattern_window u_window (
    .clk      (clk),
    .rst      (rst),
    .clr      (win_clr),
    .shift_en (shift_en),
    .bit_in   (sr_q[7]),
    .pattern  (PATTERN),
    .match    (win_match)
  );

  // A match on the final bit lands in the DONE cycle, so the report uses the updated count.
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign match_pulse   = win_match;
  assign match_id      = win_match ? grant_q : '0;
  assign frame_done    = (state_q == DONE);
  assign frame_id      = frame_done ? grant_q : '0;
  assign frame_matches = frame_done ? cnt_d : '0;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: single, spanning and back-to-back matches,
// round-robin order, stalled owner and mid-frame reset.
module tb_seq_scan_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_last;
  logic [3:0]       req_ready;
  logic             busy;
  logic [1:0]       grant_id;
  logic             match_pulse;
  logic [1:0]       match_id;
  logic             frame_done;
  logic [1:0]       frame_id;
  logic [7:0]       frame_matches;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         mcount = 0, mcyc = 0;
  logic [1:0] mid = '0;
  int         dcount = 0, dcyc = 0, fm_sum = 0;
  logic [1:0] did = '0;
  logic [7:0] dfm = '0;

  seq_scan_arbiter #(.N_REQ(4), .PATTERN(8'h60)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .busy          (busy),
    .grant_id      (grant_id),
    .match_pulse   (match_pulse),
    .match_id      (match_id),
    .frame_done    (frame_done),
    .frame_id      (frame_id),
    .frame_matches (frame_matches)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (match_pulse) begin
      mcount <= mcount + 1;
      mid    <= match_id;
      mcyc   <= cyc;
    end
    if (frame_done) begin
      dcount <= dcount + 1;
      did    <= frame_id;
      dfm    <= frame_matches;
      dcyc   <= cyc;
      fm_sum <= fm_sum + int'(frame_matches);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte and waits (bounded) for its handshake; acc is the cycle ready was seen.
  task automatic send_byte(input int r, input logic [7:0] d, input logic l, output int acc);
    logic got;
    got = 1'b0;
    acc = 0;
    req_valid[r] = 1'b1;
    req_data[r]  = d;
    req_last[r]  = l;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        acc = cyc;
      end
      @(posedge clk); #1;
    end
    req_valid[r] = 1'b0;
    check("handshake", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 300 && dcount < target; i++) begin
      @(posedge clk); #1;
    end
    check("frame_done_seen", 32'(dcount >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         acc, acc2, m0, d0, s0;
    logic       found, bad;
    logic [3:0] exp_rdy [4];
    int         exp_id [4];

    exp_rdy = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_id  = '{0, 1, 3, 0};

    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_match", 32'({match_pulse, match_id}), 32'd0);
    check("rst_done",  32'({frame_done, frame_id, frame_matches}), 32'd0);
    @(posedge clk); #1;

    // Single match: 8'h60 from requester 0
    m0 = mcount; d0 = dcount;
    send_byte(0, 8'h60, 1'b1, acc);
    wait_done(d0 + 1);
    check("single_cnt",    32'(mcount - m0), 32'd1);
    check("single_mid",    32'(mid), 32'd0);
    check("single_mcyc",   32'(mcyc - acc), 32'd9);
    check("single_dcyc",   32'(dcyc - acc), 32'd9);
    check("single_fm",     32'(dfm), 32'd1);
    check("single_fid",    32'(did), 32'd0);

    // Spanning match: 8'h06, 8'h0F from requester 2
    m0 = mcount; d0 = dcount;
    send_byte(2, 8'h06, 1'b0, acc);
    send_byte(2, 8'h0F, 1'b1, acc2);
    wait_done(d0 + 1);
    check("span_cnt",  32'(mcount - m0), 32'd1);
    check("span_mid",  32'(mid), 32'd2);
    check("span_mcyc", 32'(mcyc - acc2), 32'd5);
    check("span_fm",   32'(dfm), 32'd1);
    check("span_fid",  32'(did), 32'd2);

    // Round-robin from a fresh pointer: 0, 1, 3 hold valid; 0 keeps requesting
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m0 = mcount; d0 = dcount; s0 = fm_sum;
    req_valid = 4'b1011; req_data = '0; req_last = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (req_ready != '0) found = 1'b1;
      end
      check("rr_ready", 32'(req_ready), 32'(exp_rdy[g]));
      @(posedge clk);
      @(negedge clk);
      check("rr_grant", 32'(grant_id), 32'(exp_id[g]));
    end
    req_valid = '0;
    wait_done(d0 + 4);
    check("rr_frames", 32'(dcount - d0), 32'd4);
    check("rr_fm_sum", 32'(fm_sum - s0), 32'd0);
    check("rr_nomatch", 32'(mcount - m0), 32'd0);
    @(posedge clk); #1;

    // Stalled owner 1 while requester 2 waits
    m0 = mcount; d0 = dcount;
    send_byte(1, 8'h06, 1'b0, acc);
    req_valid[2] = 1'b1; req_data[2] = 8'h00; req_last[2] = 1'b1;
    bad = 1'b0;
    repeat (28) begin
      @(negedge clk);
      if (req_ready[2] || grant_id != 2'd1 || !busy) bad = 1'b1;
    end
    check("stall_hold",  32'(bad), 32'd0);
    check("stall_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    send_byte(1, 8'h0F, 1'b1, acc2);
    wait_done(d0 + 1);
    check("stall_cnt", 32'(mcount - m0), 32'd1);
    check("stall_mid", 32'(mid), 32'd1);
    check("stall_fm",  32'(dfm), 32'd1);
    check("stall_fid", 32'(did), 32'd1);
    send_byte(2, 8'h00, 1'b1, acc);
    wait_done(d0 + 2);
    check("after_stall_fid", 32'(did), 32'd2);

    // Non-overlapping matches: three 8'h60 bytes from requester 3
    m0 = mcount; d0 = dcount;
    send_byte(3, 8'h60, 1'b0, acc);
    send_byte(3, 8'h60, 1'b0, acc);
    send_byte(3, 8'h60, 1'b1, acc);
    wait_done(d0 + 1);
    check("nonov_cnt", 32'(mcount - m0), 32'd3);
    check("nonov_fm",  32'(dfm), 32'd3);
    check("nonov_fid", 32'(did), 32'd3);

    // Reset mid-frame; pointer first moved to 2 so the post-reset grant shows the restart
    d0 = dcount;
    send_byte(1, 8'h00, 1'b1, acc);
    wait_done(d0 + 1);
    m0 = mcount; d0 = dcount;
    send_byte(2, 8'h60, 1'b1, acc);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    check("mrst_grant", 32'(grant_id), 32'd0);
    check("mrst_out",   32'({match_pulse, frame_done, frame_matches}), 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("mrst_nomatch", 32'(mcount - m0), 32'd0);
    check("mrst_nodone",  32'(dcount - d0), 32'd0);
    req_valid = 4'b0110; req_data = '0; req_last = 4'b1111;
    @(negedge clk);
    check("mrst_next_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done(d0 + 1);
    check("mrst_next_fid", 32'(did), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
